idct2d: RTL
===========

# idct2d

Inverse 2-D 8×8 DCT engine, the decode-side counterpart of `dct2d` in the MPEG2 pipeline. It reads a 64-entry block of signed 16-bit coefficients and the shared 16-bit DCT basis matrix through combinational-read RAM ports. It computes X = Cᵀ·Y·C in two separable matrix passes through an internal transpose buffer, and writes 64 clamped unsigned 8-bit pixels to an output RAM. It uses the same `rdy`/`en` start handshake and row-major 6-bit addressing (addr = row·8 + col) as the forward engine.

## Interface
- `N`, 8: block dimension (fixed; not for override).
- `FRAC`, 14: fractional bits of matrix entries (signed Q1.14).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: start request, sampled only while `rdy`=1.
- `rdy` out 1: idle/ready; high in IDLE only.
- `iaddr` out 6: coefficient RAM address.
- `iq` in 16: signed coefficient, valid combinationally from `iaddr`.
- `maddr` out 6: matrix RAM address.
- `mq` in 16: signed Q1.14 matrix entry C[k][n], valid combinationally from `maddr`.
- `waddr` out 6: pixel write address.
- `wdata` out 8: unsigned pixel.
- `wwren` out 1: write strobe, one cycle per pixel.

## Operation
- States: IDLE, P1_MAC, P1_WR, P2_MAC, P2_WR. Counters: element index e (0..63, r = e[5:3], c = e[2:0]) and term index k (0..7).
- IDLE: `rdy`=1. At an edge with `en`=1, go to P1_MAC with e=0, k=0 and clear the accumulator.
- P1_MAC (8 cycles, k=0..7): `iaddr`=k·8+c, `maddr`=k·8+r; acc += iq·mq (signed 32-bit product, 35-bit accumulator).
- P1_WR (1 cycle): T[r][c] = sat16((acc + 2¹³) >>> 14). T is an internal 64×16 buffer. Then e+1, or go to P2_MAC with e=0 after e=63.
- P2_MAC (8 cycles): source T[r][k]; `maddr`=k·8+c. `iaddr` is held at 0 during pass 2.
- P2_WR (1 cycle): v = (acc + 2¹³) >>> 14; `wdata` = clamp(v, 0, 255); `wwren`=1; `waddr`=e. After e=63, go to IDLE.
- Arithmetic: rounding is half-up toward +∞ on the arithmetic shift. Saturation and clamp apply to the full shifted value. No wrap-around anywhere.
- Pixels are written in order 0..63, exactly 64 `wwren` pulses per block. Pass 1 never asserts `wwren`.
- `en` while busy is ignored. `en` held high at completion restarts at the first IDLE edge, so `rdy` is high for exactly one cycle.
- Reset mid-operation aborts immediately: no further writes, IDLE next cycle. T contents are don't-care.

## Timing
- Reset values: `rdy`=1 (IDLE), `wwren`=0, `iaddr`=`maddr`=`waddr`=0, `wdata`=0, accumulator and counters 0.
- Start latency: `rdy` falls the cycle after the accepting edge.
- Busy length: exactly 2·64·9 = 1152 cycles with `rdy`=0.
- The last `wwren` (`waddr`=63) occurs in busy cycle 1152. `rdy`=1 on the following cycle.
- `wdata`/`waddr`/`wwren` are registered-state outputs, stable across the whole write cycle. The RAM captures them on the next edge.

## Configuration
- `IDCT2D_LEVEL_SHIFT_EN`:
  - Defined: 128 is added to v before the 0..255 clamp, for signed-centred encoders.
  - Undefined: no offset, matching `dct2d`, which does not level-shift.
- The macro does not affect cycle timing.

## Structure
- Package `idct2d_pkg`: N, FRAC, ROUND (2¹³), coefficient/accumulator/pixel widths, state enum `idct_state_t`, and `sat16`/`clamp8` functions.
- Sub-module `idct_mac`: signed 16×16 multiply, 35-bit accumulate with clear, round-shift. It exposes the rounded result; the top applies the pass-specific saturation.
- Top `idct2d`: FSM, counters, address generation, T buffer.

## Test plan
- All-zero coefficients, C = standard Q1.14 DCT matrix (C[0][*]=0x16A1) -> 64 writes of 0, `waddr` 0..63 in order, `rdy` low exactly 1152 cycles.
- Y[0]=1024, rest 0 -> every pixel 128. With `IDCT2D_LEVEL_SHIFT_EN`, Y all 0 -> every pixel 128.
- Saturation:
  - Y[0]=4095 -> every pixel 255.
  - Y[0]=−1024 -> every pixel 0.
- Round trip: a block of `dct2d` outputs for a known pixel ramp -> reconstructed pixels within ±1 of the originals.
- Reset asserted at busy cycle 700 -> no `wwren` afterward, `rdy`=1 the next cycle. A new `en` then gives a correct full block.
- `en` held high throughout -> pulses mid-run ignored, back-to-back blocks separated by exactly one `rdy`=1 cycle.

Source files
------------

// File: rtl/idct2d_pkg.sv
// Shared constants, state encoding and saturation helpers for the 8x8 inverse DCT engine.
package idct2d_pkg;

  localparam int N     = 8;
  localparam int FRAC  = 14;
  localparam int ROUND = 1 << (FRAC - 1);
  localparam int CW    = 16;
  localparam int PW    = 2 * CW;
  localparam int AW    = PW + 3;
  localparam int RW    = AW - FRAC;
  localparam int XW    = 8;
  localparam int LEVEL = 128;

  typedef enum logic [2:0] {
    IDLE,
    P1_MAC,
    P1_WR,
    P2_MAC,
    P2_WR
  } idct_state_t;

  // The full rounded value is compared, so out-of-range results pin to the rail instead of wrapping.
  function automatic logic signed [CW-1:0] sat16(input logic signed [RW-1:0] v);
    if (v > RW'(32767))
      return 16'sh7fff;
    else if (v < RW'(-32768))
      return 16'sh8000;
    else
      return v[CW-1:0];
  endfunction

  function automatic logic [XW-1:0] clamp8(input logic signed [RW:0] v);
    if (v[RW])
      return '0;
    else if (v > (RW+1)'(255))
      return '1;
    else
      return v[XW-1:0];
  endfunction

endpackage

// File: rtl/idct2d_mac.sv
// Signed 16x16 multiply-accumulate with clear, exposing the half-up rounded Q1.14 result.
module idct_mac
  import idct2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic signed [CW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [RW-1:0] rnd
);

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] biased;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else if (acc_en)
      acc <= acc + AW'(prod);
  end

  // Eight full-scale products fit in 35 bits, so adding the rounding bias cannot overflow.
  assign biased = acc + AW'(ROUND);
  assign rnd    = RW'(biased >>> FRAC);

endmodule

// File: rtl/idct2d.sv
// 8x8 inverse 2-D DCT: X = C^T * Y * C through a 64x16 transpose buffer, clamped 8-bit pixels out.
// Optional build macro IDCT2D_LEVEL_SHIFT_EN adds 128 to each pixel before the 0..255 clamp.
module idct2d
  import idct2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 rdy,
  output logic [5:0]           iaddr,
  input  logic signed [CW-1:0] iq,
  output logic [5:0]           maddr,
  input  logic signed [CW-1:0] mq,
  output logic [5:0]           waddr,
  output logic [XW-1:0]        wdata,
  output logic                 wwren
);

  idct_state_t state, state_nxt;

  logic [5:0] e;
  logic [2:0] k;
  logic [2:0] r;
  logic [2:0] c;

  logic signed [CW-1:0] tbuf [N*N];
  logic signed [CW-1:0] mac_a;
  logic signed [RW-1:0] rnd;
  logic signed [RW:0]   pix_v;
  logic                 mac_clr;
  logic                 mac_en;

  assign r = e[5:3];
  assign c = e[2:0];

`ifdef IDCT2D_LEVEL_SHIFT_EN
  assign pix_v = (RW+1)'(rnd) + (RW+1)'(LEVEL);
`else
  assign pix_v = (RW+1)'(rnd);
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    iaddr     = '0;
    maddr     = '0;
    waddr     = '0;
    wdata     = '0;
    wwren     = 1'b0;
    mac_a     = iq;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    case (state)
      IDLE: begin
        rdy     = 1'b1;
        mac_clr = 1'b1;
        if (en)
          state_nxt = P1_MAC;
      end
      P1_MAC: begin
        iaddr  = {k, c};
        maddr  = {k, r};
        mac_en = 1'b1;
        if (k == 3'd7)
          state_nxt = P1_WR;
      end
      P1_WR: begin
        mac_clr   = 1'b1;
        state_nxt = (e == 6'd63) ? P2_MAC : P1_MAC;
      end
      P2_MAC: begin
        maddr  = {k, c};
        mac_a  = tbuf[{r, k}];
        mac_en = 1'b1;
        if (k == 3'd7)
          state_nxt = P2_WR;
      end
      P2_WR: begin
        mac_clr   = 1'b1;
        waddr     = e;
        wdata     = clamp8(pix_v);
        wwren     = 1'b1;
        state_nxt = (e == 6'd63) ? IDLE : P2_MAC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both counters wrap naturally: k after term 7, e after element 63, ready for the next pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      k <= '0;
    end else begin
      case (state)
        P1_MAC, P2_MAC: k <= k + 3'd1;
        P1_WR, P2_WR:   e <= e + 6'd1;
        default: begin
          e <= '0;
          k <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == P1_WR)
      tbuf[e] <= sat16(rnd);
  end

  idct_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .acc_en (mac_en),
    .a      (mac_a),
    .b      (mq),
    .rnd    (rnd)
  );

endmodule
